// File: rtl/spi_csr_bank.sv
// ---------------------------------------------------------------------------
// spi_csr_bank
//
// A bank of read/write control registers plus read-only status words, reached
// over a mode-0 SPI slave link. The SPI pins are asynchronous to clk; they are
// synchronized and SCK edges are recovered by oversampling (clk >= 8x SCK).
//
// Frame format (MSB first): 1 bit W (1 = write, 0 = read), ADDR_W address
// bits, then any number of DATA_W-bit data words. The address auto-increments
// after every complete word, wrapping modulo 2^ADDR_W.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   spi_cs_n          : chip select (active low, asynchronous)
//   spi_sck           : SPI clock, mode 0 (asynchronous)
//   spi_mosi          : serial data in
//   spi_miso          : serial data out, changes on SCK falling edges
//   spi_miso_oe       : high while a frame is active
//   stat_in           : NUM_STAT status words, word j at [j*DATA_W +: DATA_W]
//   reg_q             : NUM_REGS control words, word i at [i*DATA_W +: DATA_W]
//   wr_stb / wr_addr  : one-cycle pulse and address of each committed write
//   frame_err         : one-cycle pulse when a frame ends mid-word
// ---------------------------------------------------------------------------
module spi_csr_bank #(
  parameter int                          ADDR_W      = 7,
  parameter int                          DATA_W      = 8,
  parameter int                          NUM_REGS    = 16,
  parameter int                          NUM_STAT    = 4,
  parameter int                          SYNC_STAGES = 2,
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         spi_cs_n,
  input  logic                         spi_sck,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic                         spi_miso_oe,
  input  logic [NUM_STAT*DATA_W-1:0]   stat_in,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int CNT_MAX = ((ADDR_W + 1) > DATA_W) ? (ADDR_W + 1) : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FL_W    = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_dly_q, sck_dly_d;
  logic                   cs_s, sck_s, mosi_s;
  logic                   sck_rise, sck_fall;

  // Post-reset arming: frames are accepted only after CS has been seen high
  logic [FL_W-1:0]        flush_q, flush_d;
  logic                   flush_done;
  logic                   armed_q, armed_d;

  // Protocol state
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   hdr_last, data_last;

  // Shift registers and frame context (no reset needed: always loaded first)
  logic [ADDR_W-1:0]      hdr_sr_q, hdr_sr_d;
  logic [ADDR_W:0]        hdr_full;
  logic [DATA_W-2:0]      data_sr_q, data_sr_d;
  logic [DATA_W-1:0]      data_word;
  logic [DATA_W-1:0]      rd_sr_q, rd_sr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   wr_flag_q, wr_flag_d;

  // Register file and outputs
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic                   miso_q, miso_d;
  logic                   oe_q, oe_d;
  logic                   wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic                   frame_err_q, frame_err_d;

  // Read lookup
  logic [ADDR_W-1:0]      look_addr;
  logic [DATA_W-1:0]      look_word;
  logic                   commit;

  // ---------------------------------------------------------------------
  // Synchronizer chains, SCK edge detection, arming
  // ---------------------------------------------------------------------
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs_n};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0],  spi_sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  end

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_dly_d = sck_s;
  assign sck_rise = sck_s & ~sck_dly_q;
  assign sck_fall = ~sck_s & sck_dly_q;

  // The CS chain resets to 1, so it only reflects the real pin once every
  // stage has been refilled; until then a high cs_s proves nothing.
  assign flush_done = (flush_q == FL_W'(SYNC_STAGES));

  always_comb begin
    flush_d = flush_q;
    if (!flush_done) begin
      flush_d = flush_q + FL_W'(1);
    end
    armed_d = armed_q | (flush_done & cs_s);
  end

  // ---------------------------------------------------------------------
  // Header / data assembly and read-word lookup
  // ---------------------------------------------------------------------
  assign hdr_full  = {hdr_sr_q, mosi_s};
  assign data_word = {data_sr_q, mosi_s};
  assign hdr_last  = (bit_cnt_q == CNT_W'(ADDR_W));
  assign data_last = (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign commit    = wr_flag_q && (int'(addr_q) < NUM_REGS);

  // The first word of a frame comes from the address just completing in the
  // header; later words come from the incremented burst address.
  assign look_addr = (state_q == HDR) ? hdr_full[ADDR_W-1:0]
                                      : addr_q + ADDR_W'(1);

  always_comb begin
    look_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(look_addr) == i) begin
        look_word = regs_q[i*DATA_W +: DATA_W];
      end
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (int'(look_addr) == NUM_REGS + j) begin
        look_word = stat_in[j*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      regs_q      <= RESET_VAL;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_dly_q   <= sck_dly_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      regs_q      <= regs_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    hdr_sr_q  <= hdr_sr_d;
    data_sr_q <= data_sr_d;
    rd_sr_q   <= rd_sr_d;
    addr_q    <= addr_d;
    wr_flag_q <= wr_flag_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic (CS high wins over any SCK edge)
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (armed_q && !cs_s) state_d = HDR;
      HDR: begin
        if (cs_s)                      state_d = IDLE;
        else if (sck_rise && hdr_last) state_d = DATA;
      end
      DATA: if (cs_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs and datapath
  // ---------------------------------------------------------------------
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    hdr_sr_d    = hdr_sr_q;
    data_sr_d   = data_sr_q;
    rd_sr_d     = rd_sr_q;
    addr_d      = addr_q;
    wr_flag_d   = wr_flag_q;
    regs_d      = regs_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        oe_d   = 1'b0;
        if (armed_q && !cs_s) begin
          bit_cnt_d = '0;
          oe_d      = 1'b1;
        end
      end

      HDR: begin
        if (cs_s) begin
          oe_d        = 1'b0;
          miso_d      = 1'b0;
          frame_err_d = (bit_cnt_q != '0);
        end else if (sck_rise) begin
          hdr_sr_d = hdr_full[ADDR_W-1:0];
          if (hdr_last) begin
            wr_flag_d = hdr_full[ADDR_W];
            addr_d    = hdr_full[ADDR_W-1:0];
            rd_sr_d   = look_word;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      DATA: begin
        if (cs_s) begin
          // A partial word is simply dropped: writes only happen on the
          // last bit of a word, so nothing to undo here.
          oe_d        = 1'b0;
          miso_d      = 1'b0;
          frame_err_d = (bit_cnt_q != '0);
        end else begin
          if (sck_rise) begin
            data_sr_d = data_word[DATA_W-2:0];
            if (data_last) begin
              if (commit) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (int'(addr_q) == i) begin
                    regs_d[i*DATA_W +: DATA_W] = data_word;
                  end
                end
                wr_stb_d  = 1'b1;
                wr_addr_d = addr_q;
              end
              addr_d    = addr_q + ADDR_W'(1);
              rd_sr_d   = look_word;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          // Mode 0: the master samples on rising edges, so MISO moves on
          // falling edges only and holds in between.
          if (sck_fall) begin
            miso_d  = rd_sr_q[DATA_W-1];
            rd_sr_d = {rd_sr_q[DATA_W-2:0], 1'b0};
          end
        end
      end

      default: begin
        miso_d = 1'b0;
        oe_d   = 1'b0;
      end
    endcase
  end

  assign reg_q       = regs_q;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_csr_bank.sv
`timescale 1ns/1ps
module tb_spi_csr_bank;

  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int NR   = 16;
  localparam int NS   = 4;
  localparam int SS   = 2;
  localparam int HALF = 8;   // clk cycles per SCK half period (clk = 16x SCK)
  // word i = RV[i*8 +: 8]: F0 E1 D2 C3 B4 A5 96 87 78 69 5A 4B 3C 2D 1E 0F
  localparam logic [NR*DW-1:0] RV = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

  logic              clk;
  logic              rst_n;
  logic              spi_cs_n, spi_sck, spi_mosi;
  logic              spi_miso, spi_miso_oe;
  logic [NS*DW-1:0]  stat_in;
  logic [NR*DW-1:0]  reg_q;
  logic              wr_stb;
  logic [AW-1:0]     wr_addr;
  logic              frame_err;

  spi_csr_bank #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .NUM_STAT(NS),
    .SYNC_STAGES(SS), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .stat_in(stat_in), .reg_q(reg_q),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] model_regs [NR];
  logic [7:0] tx_words [8];
  logic [7:0] rx_words [8];
  logic [7:0] exp_rx [8];
  wr_t        exp_wr [$];
  int         wr_cnt = 0, ferr_cnt = 0;
  int         exp_wr_total = 0, exp_ferr_total = 0;
  bit         idle_chk = 1'b0;
  int         base_wr, base_ferr;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model_regs[i];
    return f;
  endfunction

  // Word a master reads from address a: control reg, status word, or zero.
  function automatic logic [7:0] model_word(input logic [AW-1:0] a);
    int ai;
    ai = int'(a);
    if (ai < NR) return model_regs[ai];
    if (ai < NR + NS) return stat_in[(ai - NR)*DW +: DW];
    return 8'h00;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare process: write pulses against the expected-write queue, and the
  // whole visible state against the model whenever the link is idle.
  always @(negedge clk) begin
    if (wr_stb) begin
      wr_cnt++;
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL wr_stb_unexpected: got wr_addr %0h expected no write", wr_addr);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", wr_addr, e.a);
        check("wr_data", reg_q[int'(e.a)*DW +: DW], e.d);
      end
    end
    if (frame_err) ferr_cnt++;
    if (idle_chk) begin
      check("idle_state", {reg_q, spi_miso_oe, spi_miso}, {model_flat(), 2'b00});
    end
  end

  // One SPI frame: header {w,a}, n full words from tx_words, then 'part'
  // extra bits of tx_words[n]. rst_at != 0 pulses rst_n before bit rst_at.
  task automatic spi_frame(input bit w, input logic [AW-1:0] a, input int n,
                           input int part, input int rst_at);
    logic [7:0]    hdr;
    logic [AW-1:0] ea;
    int            total, wi;
    hdr = {w, a};
    idle_chk = 1'b0;
    for (int k = 0; k < n; k++) begin
      ea = a + AW'(k);
      exp_rx[k]   = model_word(ea);
      rx_words[k] = 8'h00;
      if (w && int'(ea) < NR && (rst_at == 0 || 8 + 8*(k+1) <= rst_at)) begin
        exp_wr.push_back({ea, tx_words[k]});
        model_regs[int'(ea)] = tx_words[k];
        exp_wr_total++;
      end
    end
    if (part > 0 && rst_at == 0) exp_ferr_total++;
    total = 8 + 8*n + part;
    spi_cs_n = 1'b0;
    cyc(HALF);
    for (int idx = 0; idx < total; idx++) begin
      if (rst_at != 0 && idx == rst_at) break;
      wi = (idx - 8) / 8;
      if (idx < 8) spi_mosi = hdr[7 - idx];
      else         spi_mosi = tx_words[wi][7 - ((idx - 8) % 8)];
      cyc(HALF);
      if (idx >= 8 && wi < n) rx_words[wi] = {rx_words[wi][6:0], spi_miso};
      spi_sck = 1'b1;
      cyc(HALF);
      spi_sck = 1'b0;
    end
    if (rst_at != 0) begin
      rst_n = 1'b0;
      #1;
      check("reset_mid_frame_reg_q", reg_q, RV);
      for (int i = 0; i < NR; i++) model_regs[i] = RV[i*DW +: DW];
      cyc(3);
      rst_n = 1'b1;
      cyc(20);   // CS still low: no frame may start before CS goes high
      check("post_reset_oe_waits_cs", spi_miso_oe, 1'b0);
    end
    cyc(HALF);
    if (rst_at == 0) check("frame_oe", spi_miso_oe, 1'b1);
    spi_cs_n = 1'b1;
    if (part > 0) begin
      cyc(SS + 2);
      check("abort_oe_off", spi_miso_oe, 1'b0);
    end
    cyc(12);
    if (!w && rst_at == 0) begin
      for (int k = 0; k < n; k++) check("rx_word", rx_words[k], exp_rx[k]);
    end
    check("wr_stb_count", wr_cnt, exp_wr_total);
    check("frame_err_count", ferr_cnt, exp_ferr_total);
    check("pending_writes", exp_wr.size(), 0);
    idle_chk = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    stat_in  = 32'hAABB5C33;   // status words: 33, 5C, BB, AA
    for (int i = 0; i < 8; i++) tx_words[i] = 8'h00;
    cyc(3);
    check("reset_reg_q", reg_q, RV);
    check("reset_word3", reg_q[31:24], 8'hC3);
    check("reset_outputs", {spi_miso, spi_miso_oe, wr_stb, wr_addr, frame_err}, 11'd0);
    rst_n = 1'b1;
    cyc(10);
    for (int i = 0; i < NR; i++) model_regs[i] = RV[i*DW +: DW];
    idle_chk = 1'b1;

    // Single write 0xA5 to reg 3
    base_wr = wr_cnt;
    tx_words[0] = 8'hA5;
    spi_frame(1'b1, 7'h03, 1, 0, 0);
    check("w03_word3", reg_q[31:24], 8'hA5);
    check("w03_word2", reg_q[23:16], 8'hD2);
    check("w03_word4", reg_q[39:32], 8'hB4);
    check("w03_one_stb", wr_cnt - base_wr, 1);

    // Read it back
    tx_words[0] = 8'h00;
    spi_frame(1'b0, 7'h03, 1, 0, 0);
    check("r03_literal", rx_words[0], 8'hA5);

    // Burst write from reg 15 into status space
    base_wr = wr_cnt;
    tx_words[0] = 8'h11;
    tx_words[1] = 8'h22;
    spi_frame(1'b1, 7'h0F, 2, 0, 0);
    check("w0f_word15", reg_q[127:120], 8'h11);
    check("w0f_one_stb", wr_cnt - base_wr, 1);

    // Status reads
    spi_frame(1'b0, 7'h11, 1, 0, 0);
    check("r11_literal", rx_words[0], 8'h5C);
    spi_frame(1'b0, 7'h10, 2, 0, 0);
    check("r10_literal", rx_words[0], 8'h33);
    check("r11_burst_literal", rx_words[1], 8'h5C);

    // Wrap from the last address to 0
    spi_frame(1'b0, 7'h7F, 2, 0, 0);
    check("r7f_literal", rx_words[0], 8'h00);
    check("r00_wrap_literal", rx_words[1], 8'hF0);

    // Abort after 4 data bits of a write
    base_ferr = ferr_cnt;
    tx_words[0] = 8'h3C;
    spi_frame(1'b1, 7'h05, 0, 4, 0);
    check("abort_word5", reg_q[47:40], 8'hA5);
    check("abort_one_ferr", ferr_cnt - base_ferr, 1);

    // Burst write of three registers, burst read across them
    tx_words[0] = 8'h12;
    tx_words[1] = 8'h34;
    tx_words[2] = 8'h56;
    spi_frame(1'b1, 7'h06, 3, 0, 0);
    spi_frame(1'b0, 7'h05, 5, 0, 0);
    check("rb_w5", rx_words[0], 8'hA5);
    check("rb_w6", rx_words[1], 8'h12);
    check("rb_w7", rx_words[2], 8'h34);
    check("rb_w8", rx_words[3], 8'h56);
    check("rb_w9", rx_words[4], 8'h69);

    // Reset in the middle of a burst (after word 0 and 3 bits of word 1)
    tx_words[0] = 8'hEE;
    tx_words[1] = 8'hDD;
    spi_frame(1'b1, 7'h08, 2, 0, 19);
    check("rst_word8", reg_q[71:64], 8'h78);

    // Next frame after reset completes normally
    tx_words[0] = 8'h7E;
    spi_frame(1'b1, 7'h02, 1, 0, 0);
    spi_frame(1'b0, 7'h02, 1, 0, 0);
    check("post_rst_r02_literal", rx_words[0], 8'h7E);

    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
